// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-flag helper for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DefWidth       = 8;
  localparam int unsigned DefDepthLog2   = 9;
  // almost_full sits this many entries below capacity by default
  localparam int unsigned DefAfullMargin = 16;
  localparam int unsigned DefAemptyLevel = 16;

  typedef struct packed {
    logic full;
    logic empty;
  } ptr_flags_t;

  // Pointers carry one wrap bit above the address bits (aw = address width).
  // Equal pointers mean empty; equal address bits with differing wrap bits mean full.
  function automatic ptr_flags_t ptr_flags(input logic [31:0] wr_ptr, input logic [31:0] rd_ptr,
                                           input int unsigned aw);
    logic [31:0] lo_mask;
    logic [31:0] wrap_bit;
    logic [31:0] diff;
    ptr_flags_t  flags;
    wrap_bit    = 32'd1 << aw;
    lo_mask     = wrap_bit - 32'd1;
    diff        = wr_ptr ^ rd_ptr;
    flags.empty = ((diff & (lo_mask | wrap_bit)) == 32'd0);
    flags.full  = ((diff & lo_mask) == 32'd0) && ((diff & wrap_bit) != 32'd0);
    return flags;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset,
// so that synthesis can map it onto block RAM.
module fifo_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [Depth];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port; read data holds while re_i is low.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parameterised synchronous FIFO with registered occupancy flags and sticky
// overflow/underflow. push/pop requests (wr, rd) are active-low.
// Define FIFO_SYNC_PARAM_FWFT_EN for first-word-fall-through reads; otherwise an
// accepted pop loads rd_data at that edge.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = DefWidth,
  parameter int unsigned DEPTH_LOG2   = DefDepthLog2,
  parameter int unsigned AFULL_LEVEL  = (1 << DEPTH_LOG2) - DefAfullMargin,
  parameter int unsigned AEMPTY_LEVEL = DefAemptyLevel
) (
  input  logic                  clk,
  input  logic                  nrst,
  output logic                  not_empty,
  input  logic                  rd,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  not_full,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;
  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  level_q, level_d;
  logic             not_empty_q, not_empty_d;
  logic             not_full_q, not_full_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             push_acc, pop_acc;
  logic             ram_we, ram_re;
  logic [WIDTH-1:0] ram_rdata;
  ptr_flags_t       cur_flags;

`ifdef FIFO_SYNC_PARAM_FWFT_EN
  // mid stage = RAM read register; output stage = out_q, valid when not_empty_q
  logic             mid_valid_q, mid_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             move;
`else
  // rd_data reads as zero until the first pop after reset loads the RAM register
  logic             rd_loaded_q, rd_loaded_d;
  ptr_flags_t       nxt_flags;
`endif

  fifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (wr_data),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o (ram_rdata)
  );

  // Acceptance from pre-edge flags, next pointers, occupancy and flag values.
  always_comb begin
    push_acc  = !wr && not_full_q;
    pop_acc   = !rd && not_empty_q;
    cur_flags = ptr_flags(32'(wr_ptr_q), 32'(rd_ptr_q), DEPTH_LOG2);
    // RAM-full guard is redundant with not_full_q but keeps storage uncorruptible
    ram_we    = push_acc && !cur_flags.full;
    wr_ptr_d  = wr_ptr_q + PtrW'(ram_we);

`ifdef FIFO_SYNC_PARAM_FWFT_EN
    move        = mid_valid_q && (!not_empty_q || pop_acc);
    // Prefetch from RAM whenever it holds data and the mid stage is free or draining
    ram_re      = !cur_flags.empty && (!mid_valid_q || move);
    rd_ptr_d    = rd_ptr_q + PtrW'(ram_re);
    mid_valid_d = ram_re || (mid_valid_q && !move);
    not_empty_d = move || (not_empty_q && !pop_acc);
    out_d       = move ? ram_rdata : out_q;
    // Occupancy includes entries in flight and in the output stage
    level_d     = level_q + PtrW'(ram_we) - PtrW'(pop_acc);
    not_full_d  = (32'(level_d) != Depth);
`else
    ram_re      = pop_acc && !cur_flags.empty;
    rd_ptr_d    = rd_ptr_q + PtrW'(ram_re);
    nxt_flags   = ptr_flags(32'(wr_ptr_d), 32'(rd_ptr_d), DEPTH_LOG2);
    level_d     = wr_ptr_d - rd_ptr_d;
    not_empty_d = !nxt_flags.empty;
    not_full_d  = !nxt_flags.full;
    rd_loaded_d = rd_loaded_q | ram_re;
`endif

    almost_full_d  = (32'(level_d) >= AFULL_LEVEL);
    almost_empty_d = (32'(level_d) <= AEMPTY_LEVEL);
    overflow_d     = overflow_q | (!wr && !not_full_q);
    underflow_d    = underflow_q | (!rd && !not_empty_q);
  end

  // All pointer and flag state, with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      not_empty_q    <= 1'b0;
      not_full_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
`ifdef FIFO_SYNC_PARAM_FWFT_EN
      mid_valid_q    <= 1'b0;
      out_q          <= '0;
`else
      rd_loaded_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      not_empty_q    <= not_empty_d;
      not_full_q     <= not_full_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
`ifdef FIFO_SYNC_PARAM_FWFT_EN
      mid_valid_q    <= mid_valid_d;
      out_q          <= out_d;
`else
      rd_loaded_q    <= rd_loaded_d;
`endif
    end
  end

`ifdef FIFO_SYNC_PARAM_FWFT_EN
  assign rd_data = out_q;
`else
  assign rd_data = rd_loaded_q ? ram_rdata : '0;
`endif

  assign level        = level_q;
  assign not_empty    = not_empty_q;
  assign not_full     = not_full_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (16 x 8 configuration) against a
// queue-based reference model.
module tb_fifo_sync_param;

  localparam int unsigned Depth = 16;

  logic       clk = 1'b0;
  logic       nrst;
  logic       not_empty;
  logic       rd;
  logic [7:0] rd_data;
  logic       not_full;
  logic       wr;
  logic [7:0] wr_data;
  logic [4:0] level;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  always #5 clk = ~clk;

  fifo_sync_param #(
    .WIDTH        (8),
    .DEPTH_LOG2   (4),
    .AFULL_LEVEL  (12),
    .AEMPTY_LEVEL (2)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .not_empty    (not_empty),
    .rd           (rd),
    .rd_data      (rd_data),
    .not_full     (not_full),
    .wr           (wr),
    .wr_data      (wr_data),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: contents as a queue, last popped word, sticky errors
  logic [7:0] mq[$];
  logic [7:0] m_rd_data;
  bit         m_ovf;
  bit         m_unf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned n;
    n = mq.size();
    check_val({tag, " level"}, 32'(level), n);
    check_val({tag, " not_empty"}, 32'(not_empty), 32'(n > 0));
    check_val({tag, " not_full"}, 32'(not_full), 32'(n < Depth));
    check_val({tag, " almost_full"}, 32'(almost_full), 32'(n >= 12));
    check_val({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= 2));
    check_val({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    check_val({tag, " underflow"}, 32'(underflow), 32'(m_unf));
    check_val({tag, " rd_data"}, 32'(rd_data), 32'(m_rd_data));
  endtask

  // One clock with the given requests; ends on the following falling edge.
  task automatic cyc(input bit push, input bit pop, input logic [7:0] d);
    wr      = ~push;
    rd      = ~pop;
    wr_data = d;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b1;
    rd = 1'b1;
  endtask

  task automatic model_edge(input bit push, input bit pop, input logic [7:0] d);
    bit full;
    bit empty;
    full  = (mq.size() == Depth);
    empty = (mq.size() == 0);
    if (push && full) m_ovf = 1'b1;
    if (pop && empty) m_unf = 1'b1;
    if (pop && !empty) m_rd_data = mq.pop_front();
    if (push && !full) mq.push_back(d);
  endtask

  task automatic step(input bit push, input bit pop, input logic [7:0] d, input string tag);
    cyc(push, pop, d);
    model_edge(push, pop, d);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    nrst = 1'b0;
    wr   = 1'b1;
    rd   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    mq.delete();
    m_rd_data = 8'h00;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    check_all(tag);
  endtask

  initial begin
    nrst    = 1'b0;
    wr      = 1'b1;
    rd      = 1'b1;
    wr_data = 8'h00;
    @(negedge clk);
    do_reset("reset");

`ifndef FIFO_SYNC_PARAM_FWFT_EN
    // Fill, then one push too many
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), "fill");
    step(1'b1, 1'b0, 8'hAA, "fill_over");
    check_val("fill_level", 32'(level), 32'd16);
    check_val("fill_ovf", 32'(overflow), 32'd1);

    // Drain in order, then one pop too many
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, "drain");
    check_val("drain_last", 32'(rd_data), 32'h0F);
    step(1'b0, 1'b1, 8'h00, "drain_under");
    check_val("drain_unf", 32'(underflow), 32'd1);

    // Steady push+pop at level 5 across pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), "pre_sim");
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'($urandom), "simul");
    check_val("simul_level", 32'(level), 32'd5);

    // Push+pop while empty and while full
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "to_empty");
    step(1'b1, 1'b1, 8'h77, "both_empty");
    check_val("both_empty_level", 32'(level), 32'd1);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'($urandom), "to_full");
    step(1'b1, 1'b1, 8'h99, "both_full");
    check_val("both_full_level", 32'(level), 32'd15);

    // Reset at level 7, then the next push comes out first
    do_reset("reset2");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'($urandom), "to_seven");
    do_reset("reset_mid");
    step(1'b1, 1'b0, 8'h5C, "push_5c");
    step(1'b0, 1'b1, 8'h00, "pop_5c");
    check_val("first_after_reset", 32'(rd_data), 32'h5C);

    // Random traffic
    do_reset("reset3");
    for (int i = 0; i < 400; i++) begin
      bit pu;
      bit po;
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 50);
      step(pu, po, 8'($urandom), "random");
    end
`else
    // First-word-fall-through: data visible two edges after a push into empty
    cyc(1'b1, 1'b0, 8'h3C);
    check_val("fwft_e1_not_empty", 32'(not_empty), 32'd0);
    check_val("fwft_e1_level", 32'(level), 32'd1);
    cyc(1'b0, 1'b0, 8'h00);
    check_val("fwft_e2_not_empty", 32'(not_empty), 32'd0);
    cyc(1'b0, 1'b0, 8'h00);
    check_val("fwft_e3_not_empty", 32'(not_empty), 32'd1);
    check_val("fwft_e3_rd_data", 32'(rd_data), 32'h3C);
    cyc(1'b0, 1'b1, 8'h00);
    check_val("fwft_pop_level", 32'(level), 32'd0);
    check_val("fwft_pop_not_empty", 32'(not_empty), 32'd0);
    check_val("fwft_pop_unf", 32'(underflow), 32'd0);

    cyc(1'b1, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 8'h22);
    cyc(1'b1, 1'b0, 8'h33);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);
    check_val("fwft_three_level", 32'(level), 32'd3);
    check_val("fwft_three_head", 32'(rd_data), 32'h11);
    check_val("fwft_three_aempty", 32'(almost_empty), 32'd0);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check_val("fwft_second", 32'(rd_data), 32'h22);
    check_val("fwft_second_level", 32'(level), 32'd2);
    check_val("fwft_second_aempty", 32'(almost_empty), 32'd1);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check_val("fwft_third", 32'(rd_data), 32'h33);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check_val("fwft_drained", 32'(not_empty), 32'd0);
    check_val("fwft_drained_level", 32'(level), 32'd0);
    cyc(1'b0, 1'b1, 8'h00);
    check_val("fwft_unf", 32'(underflow), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
